// File: rtl/mult_operand_feeder.sv
// Operand-pair FIFO feeding an external multiplier through a one-outstanding
// issue / wait / ack / output handshake, with overflow and timeout flags.
module mult_operand_feeder #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       iPush,
  input  logic [DATA_W-1:0]          iData_A,
  input  logic [DATA_W-1:0]          iData_B,
  output logic                       oFull,
  output logic [$clog2(DEPTH):0]     oCount,
  output logic [DATA_W-1:0]          oMult_A,
  output logic [DATA_W-1:0]          oMult_B,
  output logic                       oMult_Valid,
  output logic                       oMult_Ack,
  input  logic                       iMult_Done,
  input  logic                       iMult_Idle,
  input  logic [2*DATA_W-1:0]        iMult_Result,
  output logic [2*DATA_W-1:0]        oResult,
  output logic                       oResult_Valid,
  input  logic                       iResult_Ready,
  output logic                       oOverflow,
  output logic                       oTimeout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_DONE, S_ACK, S_OUTPUT
  } state_t;

  logic [DEPTH-1:0][2*DATA_W-1:0] mem;
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;
  logic              pop, push_ok, full;
  logic [2*DATA_W-1:0] head;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic                mvld_q, mvld_d, ack_q, ack_d, rvld_q, rvld_d, tmo_flag_q, tmo_flag_d;
  logic [2*DATA_W-1:0] res_q, res_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;

  assign full    = (count_q == FULL_CNT);
  assign head    = mem[rd_q];
  assign pop     = (state_q == S_IDLE) && (count_q != '0) && iMult_Idle;
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign push_ok = iPush && (!full || pop);

  always_ff @(posedge Clock) begin
    if (push_ok && !Reset) mem[wr_q] <= {iData_A, iData_B};
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (iPush && !push_ok) ovf_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    mvld_d     = 1'b0;
    ack_d      = ack_q;
    rvld_d     = rvld_q;
    res_d      = res_q;
    tmo_d      = tmo_q;
    tmo_flag_d = tmo_flag_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          a_d     = head[2*DATA_W-1:DATA_W];
          b_d     = head[DATA_W-1:0];
          mvld_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (iMult_Done) begin
          res_d   = iMult_Result;
          ack_d   = 1'b1;
          state_d = S_ACK;
        end else if (tmo_q == TMO_LAST) begin
          // Give up on this pair; nothing is presented to the consumer.
          tmo_flag_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_ACK: begin
        if (!iMult_Done) begin
          ack_d   = 1'b0;
          rvld_d  = 1'b1;
          state_d = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (iResult_Ready) begin
          rvld_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      mvld_q     <= 1'b0;
      ack_q      <= 1'b0;
      rvld_q     <= 1'b0;
      res_q      <= '0;
      tmo_q      <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mvld_q     <= mvld_d;
      ack_q      <= ack_d;
      rvld_q     <= rvld_d;
      res_q      <= res_d;
      tmo_q      <= tmo_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign oFull         = full;
  assign oCount        = count_q;
  assign oOverflow     = ovf_q;
  assign oMult_A       = a_q;
  assign oMult_B       = b_q;
  assign oMult_Valid   = mvld_q;
  assign oMult_Ack     = ack_q;
  assign oResult       = res_q;
  assign oResult_Valid = rvld_q;
  assign oTimeout      = tmo_flag_q;

endmodule

// File: doc/mult_operand_feeder.md
MULT_OPERAND_FEEDER -- requirements
Module: mult_operand_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width; products are 2*DATA_W.
REQ-002 SHALL have parameter DEPTH, default 4, operand-pair FIFO entries; power of 2, at least 2.
REQ-003 SHALL have parameter TIMEOUT, default 1024, maximum cycles waiting for multiplier completion.
REQ-004 SHALL have one clock and a synchronous, active-high reset: Clock in, 1 bit, rising-edge clock; Reset in, 1 bit, synchronous active-high reset.
REQ-005 SHALL have ports: iPush in 1, write operand pair; iData_A in DATA_W; iData_B in DATA_W; oFull out 1; oCount out log2(DEPTH)+1, FIFO occupancy.
REQ-006 SHALL have multiplier-side ports: oMult_A out DATA_W; oMult_B out DATA_W; oMult_Valid out 1; oMult_Ack out 1; iMult_Done in 1; iMult_Idle in 1; iMult_Result in 2*DATA_W.
REQ-007 SHALL have consumer-side ports: oResult out 2*DATA_W; oResult_Valid out 1; iResult_Ready in 1; oOverflow out 1, sticky; oTimeout out 1, sticky.

Function
REQ-008 SHALL buffer operand pairs in a DEPTH-entry circular FIFO; iPush with oFull=0 writes {iData_A,iData_B} at the write pointer; pointers wrap modulo DEPTH.
REQ-009 SHALL drive oFull=1 exactly when oCount==DEPTH; push while full discards data, leaves FIFO unchanged, sets oOverflow.
REQ-010 SHALL accept a push and a pop in the same cycle when full or non-empty: count unchanged, both pointers advance; push-while-full with simultaneous pop is accepted with no overflow.
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT_DONE, ACK, OUTPUT, all with registered outputs.
REQ-012 IDLE SHALL go to ISSUE when FIFO non-empty and iMult_Idle=1; on that transition it SHALL load oMult_A/oMult_B from the FIFO head and pop the FIFO.
REQ-013 ISSUE SHALL assert oMult_Valid for exactly one cycle with oMult_A/B stable, then go to WAIT_DONE; oMult_A/B SHALL hold until the next issue.
REQ-014 WAIT_DONE SHALL, on iMult_Done=1, capture iMult_Result into oResult and go to ACK; oMult_Ack SHALL assert in the ACK state.
REQ-015 ACK SHALL hold oMult_Ack=1 until iMult_Done=0, then deassert oMult_Ack and go to OUTPUT.
REQ-016 OUTPUT SHALL hold oResult_Valid=1 with oResult stable until iResult_Ready=1; in that cycle it SHALL return to IDLE, with oResult_Valid=0 from the next cycle.
REQ-017 SHALL count cycles in WAIT_DONE; when the count reaches TIMEOUT without iMult_Done, it SHALL set oTimeout, drop the pending pair (no result produced), and go to IDLE.
REQ-018 Minimum latency from first push into an empty FIFO with iMult_Idle=1 SHALL be: oMult_Valid 2 cycles after the push edge; oResult_Valid 1 cycle after the ACK exit.
REQ-019 SHALL keep at most one operation outstanding; FIFO pushes remain accepted in every state.
REQ-020 oResult SHALL be the unmodified 2*DATA_W multiplier product; no arithmetic is performed in this block.

Reset
REQ-021 When Reset=1 at a rising edge, the block SHALL clear FIFO pointers and count, set state to IDLE, and drive oMult_Valid=0, oMult_Ack=0, oResult_Valid=0, oResult=0, oMult_A=0, oMult_B=0, oOverflow=0, oTimeout=0, oFull=0.
REQ-022 Reset asserted mid-operation (any state) SHALL abandon the in-flight pair and buffered pairs, taking effect on the same edge.
REQ-023 Push while Reset=1 SHALL be ignored.

Verification
REQ-024 Single op: push A=7, B=9; the multiplier model returns 63 with Done -> oMult_Valid pulse 1 cycle, Ack raised until Done drops, oResult=63, oResult_Valid held until Ready.
REQ-025 Fill/overflow: DEPTH=4; 5 pushes while iMult_Idle=0 -> oFull=1 after 4th, oCount=4, oOverflow=1; then results for the first 4 pairs emerge in order.
REQ-026 Simultaneous push/pop at full: push on the IDLE->ISSUE cycle -> oCount stays 4, oOverflow stays 0.
REQ-027 Back-pressure: iResult_Ready=0 for 20 cycles -> oResult and oResult_Valid stable, no new oMult_Valid.
REQ-028 Timeout: TIMEOUT=16, Done never asserted -> oTimeout=1 at cycle 16 of WAIT_DONE, FSM back in IDLE, next pair issued.
REQ-029 Reset in WAIT_DONE with 3 pairs queued -> next cycle oCount=0, all outputs at reset values, no Ack issued.
